// File: rtl/alu_pipe_param.sv
// alu_pipe_param: two-stage pipelined ALU with a valid/ready handshake on both sides.
// Stage 1 captures the operand bundle, stage 2 computes and registers the result
// and its carry/zero/sign flags. Both stages advance together so one bundle can be
// accepted and one delivered every cycle while the consumer keeps out_ready high.
// Optional feature: define ALU_ILLEGAL_OP_EN to add the sticky illegalOp output.
// Operations: 0 ROL, 1 ROR, 2 MAX, 3 MIN, 4 PASSB, 5 NOR, 6 SMAX, 7 SMIN; 8..15 produce zero.

module alu_pipe_param #(
    parameter int WIDTH = 16,
    parameter int SHW   = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [3:0]       opcode,
    input  logic [WIDTH-1:0] input1,
    input  logic [WIDTH-1:0] input2,
    input  logic [SHW-1:0]   shiftValue,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             carryFlag,
    output logic             zeroFlag,
    output logic             signFlag
`ifdef ALU_ILLEGAL_OP_EN
    ,
    output logic             illegalOp
`endif
);

    typedef enum logic [3:0] {
        OP_ROL   = 4'd0,
        OP_ROR   = 4'd1,
        OP_MAX   = 4'd2,
        OP_MIN   = 4'd3,
        OP_PASSB = 4'd4,
        OP_NOR   = 4'd5,
        OP_SMAX  = 4'd6,
        OP_SMIN  = 4'd7
    } aluOp_e;

    // Stage 1 holding registers
    logic             s1Valid;
    logic [3:0]       s1Op;
    logic [WIDTH-1:0] s1A;
    logic [WIDTH-1:0] s1B;
    logic [SHW-1:0]   s1Shift;

    // Handshake / advance controls
    logic s2Load;
    logic inFire;

    // Combinational ALU datapath between the stages
    logic [31:0]        rotAmt;
    logic [2*WIDTH-1:0] dblA;
    logic [WIDTH-1:0]   rolVal;
    logic [WIDTH-1:0]   rorVal;
    logic               ltUnsigned;
    logic               ltSigned;
    logic               eqAB;
    logic [WIDTH-1:0]   aluResult;
    logic               aluCarry;
    logic               aluZero;
    logic               aluSign;

    // Stage 2 may take a new bundle when it is empty or its content leaves this
    // cycle; stage 1 may take one when it is empty or moves into stage 2. Neither
    // depends on in_valid, so in_ready has no combinational path from in_valid.
    assign s2Load   = !out_valid || out_ready;
    assign in_ready = !s1Valid || s2Load;
    assign inFire   = in_valid && in_ready;

    // Stage 1: capture the operand bundle whenever the slot is free or draining
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            s1Valid <= 1'b0;
            s1Op    <= '0;
            s1A     <= '0;
            s1B     <= '0;
            s1Shift <= '0;
        end else if (in_ready) begin
            s1Valid <= in_valid;
            if (in_valid) begin
                s1Op    <= opcode;
                s1A     <= input1;
                s1B     <= input2;
                s1Shift <= shiftValue;
            end
        end
    end

    // Rotate amount is reduced modulo WIDTH; rotations come from a doubled copy of
    // input1 so that amount 0 naturally returns the operand unchanged.
    always_comb begin
        rotAmt     = 32'(s1Shift) % 32'(WIDTH);
        dblA       = {s1A, s1A};
        rolVal     = WIDTH'(dblA >> (32'(WIDTH) - rotAmt));
        rorVal     = WIDTH'(dblA >> rotAmt);
        ltUnsigned = (s1A < s1B);
        ltSigned   = ($signed(s1A) < $signed(s1B));
        eqAB       = (s1A == s1B);
    end

    // Operation select; compare ops return input2 on a tie and report A<B as carry
    always_comb begin
        aluResult = '0;
        aluCarry  = 1'b0;
        case (s1Op)
            OP_ROL: begin
                aluResult = rolVal;
                aluCarry  = (rotAmt != 32'd0) ? rolVal[0] : 1'b0;
            end
            OP_ROR: begin
                aluResult = rorVal;
                aluCarry  = (rotAmt != 32'd0) ? rorVal[WIDTH-1] : 1'b0;
            end
            OP_MAX: begin
                aluResult = (ltUnsigned || eqAB) ? s1B : s1A;
                aluCarry  = ltUnsigned;
            end
            OP_MIN: begin
                aluResult = (ltUnsigned && !eqAB) ? s1A : s1B;
                aluCarry  = ltUnsigned;
            end
            OP_PASSB: begin
                aluResult = s1B;
                aluCarry  = 1'b0;
            end
            OP_NOR: begin
                aluResult = ~(s1A | s1B);
                aluCarry  = 1'b0;
            end
            OP_SMAX: begin
                aluResult = (ltSigned || eqAB) ? s1B : s1A;
                aluCarry  = ltSigned;
            end
            OP_SMIN: begin
                aluResult = (ltSigned && !eqAB) ? s1A : s1B;
                aluCarry  = ltSigned;
            end
            default: begin
                aluResult = '0;
                aluCarry  = 1'b0;
            end
        endcase
        aluZero = (aluResult == '0);
        aluSign = aluResult[WIDTH-1];
    end

    // Stage 2: register result and flags; hold them untouched while stalled
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            result    <= '0;
            carryFlag <= 1'b0;
            zeroFlag  <= 1'b0;
            signFlag  <= 1'b0;
        end else if (s2Load) begin
            out_valid <= s1Valid;
            if (s1Valid) begin
                result    <= aluResult;
                carryFlag <= aluCarry;
                zeroFlag  <= aluZero;
                signFlag  <= aluSign;
            end
        end
    end

`ifdef ALU_ILLEGAL_OP_EN
    // Sticky marker set when an opcode outside 0..7 is accepted; only reset clears it
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            illegalOp <= 1'b0;
        end else if (inFire && opcode[3]) begin
            illegalOp <= 1'b1;
        end
    end
`else
    // Without the status output an illegal opcode just yields a zero result
    logic unusedFire;
    assign unusedFire = inFire;
`endif

endmodule

// File: tb/tb_alu_pipe_param.sv
// tb_alu_pipe_param: scoreboard bench for alu_pipe_param at WIDTH=16.
// Expected results are computed by a loop-based reference model when a bundle is
// accepted and compared in order when the pipeline delivers.

module tb_alu_pipe_param;

    localparam int W  = 16;
    localparam int SW = 4;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          in_valid;
    logic          in_ready;
    logic [3:0]    opcode;
    logic [W-1:0]  input1;
    logic [W-1:0]  input2;
    logic [SW-1:0] shiftValue;
    logic          out_valid;
    logic          out_ready;
    logic [W-1:0]  result;
    logic          carryFlag;
    logic          zeroFlag;
    logic          signFlag;
`ifdef ALU_ILLEGAL_OP_EN
    logic          illegalOp;
`endif

    typedef struct packed {
        logic [W-1:0] r;
        logic         c;
        logic         z;
        logic         s;
    } exp_t;

    exp_t sb[$];
    int   deliverCycles[$];
    int   checkCount = 0;
    int   errorCount = 0;
    int   cycle = 0;
    bit   randBp = 1'b0;
    logic readyForce = 1'b1;

    alu_pipe_param #(.WIDTH(W)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .opcode     (opcode),
        .input1     (input1),
        .input2     (input2),
        .shiftValue (shiftValue),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .result     (result),
        .carryFlag  (carryFlag),
        .zeroFlag   (zeroFlag),
        .signFlag   (signFlag)
`ifdef ALU_ILLEGAL_OP_EN
        ,
        .illegalOp  (illegalOp)
`endif
    );

    always #5 clk = ~clk;

    always @(posedge clk) cycle <= cycle + 1;

    task automatic checkOutput(input string tag, input logic [63:0] actual, input logic [63:0] expected);
        checkCount++;
        if (actual !== expected) begin
            errorCount++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
        end
    endtask

    function automatic exp_t model(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                                   input logic [SW-1:0] sh);
        exp_t         e;
        int           amt;
        logic [W-1:0] r;
        e   = '0;
        amt = int'(sh) % W;
        r   = a;
        case (op)
            4'd0: begin
                for (int i = 0; i < amt; i++) r = {r[W-2:0], r[W-1]};
                e.r = r;
                e.c = (amt != 0) && r[0];
            end
            4'd1: begin
                for (int i = 0; i < amt; i++) r = {r[0], r[W-1:1]};
                e.r = r;
                e.c = (amt != 0) && r[W-1];
            end
            4'd2: begin e.r = (a > b) ? a : b; e.c = (a < b); end
            4'd3: begin e.r = (a < b) ? a : b; e.c = (a < b); end
            4'd4: e.r = b;
            4'd5: e.r = ~(a | b);
            4'd6: begin e.r = ($signed(a) > $signed(b)) ? a : b; e.c = ($signed(a) < $signed(b)); end
            4'd7: begin e.r = ($signed(a) < $signed(b)) ? a : b; e.c = ($signed(a) < $signed(b)); end
            default: e.r = '0;
        endcase
        e.z = (e.r == '0);
        e.s = e.r[W-1];
        return e;
    endfunction

    // Consumer backpressure: forced level or random, updated just after each edge
    initial begin
        out_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            out_ready = randBp ? 1'($urandom_range(0, 1)) : readyForce;
        end
    end

    // Monitor: observes handshakes at the falling edge, ahead of the edge that completes them
    initial begin
        exp_t cur;
        exp_t heldVal;
        exp_t e;
        bit   holdPending;
        holdPending = 1'b0;
        heldVal     = '0;
        forever begin
            @(negedge clk);
            cur = {result, carryFlag, zeroFlag, signFlag};
            if (!rst_n) begin
                sb.delete();
                holdPending = 1'b0;
            end else begin
                if (holdPending) checkOutput("stall_hold", 64'(cur), 64'(heldVal));
                if (out_valid && out_ready) begin
                    if (sb.size() == 0) begin
                        checkOutput("unexpected_out", 64'(out_valid), 64'd0);
                    end else begin
                        e = sb.pop_front();
                        checkOutput("result_flags", 64'(cur), 64'(e));
                        deliverCycles.push_back(cycle);
                    end
                end
                if (in_valid && in_ready) sb.push_back(model(opcode, input1, input2, shiftValue));
                holdPending = out_valid && !out_ready;
                heldVal     = cur;
            end
        end
    end

    task automatic driveInputs(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                               input logic [SW-1:0] sh);
        opcode     = op;
        input1     = a;
        input2     = b;
        shiftValue = sh;
        in_valid   = 1'b1;
    endtask

    // Present one bundle and hold it until accepted; returns just after the accepting edge
    task automatic applyStimulus(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                                 input logic [SW-1:0] sh);
        bit acc;
        acc = 1'b0;
        driveInputs(op, a, b, sh);
        for (int n = 0; n < 200 && !acc; n++) begin
            @(negedge clk);
            acc = in_ready;
            @(posedge clk);
            #2;
        end
        if (!acc) checkOutput("accept_timeout", 64'(acc), 64'd1);
        in_valid = 1'b0;
    endtask

    task automatic drain();
        for (int n = 0; n < 400 && sb.size() != 0; n++) begin
            @(posedge clk);
            #2;
        end
        if (sb.size() != 0) checkOutput("drain_timeout", 64'(sb.size()), 64'd0);
        repeat (2) @(posedge clk);
        #2;
    endtask

    initial begin
        #300000;
        $display("[TB] FAIL watchdog: simulation did not complete in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        // Reset with a junk bundle offered; it must be ignored
        rst_n = 1'b0;
        driveInputs(4'd4, 16'hDEAD, 16'hBEEF, 4'd3);
        repeat (3) @(posedge clk);
        #2;
        rst_n    = 1'b1;
        in_valid = 1'b0;
        @(negedge clk);
        checkOutput("rst_out_valid", 64'(out_valid), 64'd0);
        checkOutput("rst_result", 64'(result), 64'd0);
        checkOutput("rst_flags", 64'({carryFlag, zeroFlag, signFlag}), 64'd0);
        checkOutput("rst_in_ready", 64'(in_ready), 64'd1);
`ifdef ALU_ILLEGAL_OP_EN
        checkOutput("rst_illegal", 64'(illegalOp), 64'd0);
`endif
        @(posedge clk);
        #2;

        // ROL 0x8001 by 1: two-cycle latency, 0x0003 with carry out
        applyStimulus(4'd0, 16'h8001, 16'h0000, 4'd1);
        @(negedge clk);
        checkOutput("lat_stage1", 64'(out_valid), 64'd0);
        @(negedge clk);
        checkOutput("lat_stage2", 64'(out_valid), 64'd1);
        checkOutput("rol_result", 64'(result), 64'h0003);
        checkOutput("rol_flags", 64'({carryFlag, zeroFlag, signFlag}), 64'b100);
        drain();

        // ROR by 0 then by 4, back-to-back deliveries
        deliverCycles.delete();
        applyStimulus(4'd1, 16'h1234, 16'h0000, 4'd0);
        applyStimulus(4'd1, 16'h1234, 16'h0000, 4'd4);
        drain();
        checkOutput("ror_count", 64'(deliverCycles.size()), 64'd2);
        if (deliverCycles.size() >= 2)
            checkOutput("ror_b2b", 64'(deliverCycles[1] - deliverCycles[0]), 64'd1);
        checkOutput("ror4_result", 64'(result), 64'h4123);

        // Compare and logic ops on 0xFFFF vs 0x0001, plus ties and other rotates
        applyStimulus(4'd2, 16'hFFFF, 16'h0001, 4'd0);
        applyStimulus(4'd6, 16'hFFFF, 16'h0001, 4'd0);
        applyStimulus(4'd5, 16'hFFFF, 16'h0001, 4'd0);
        applyStimulus(4'd3, 16'hFFFF, 16'h0001, 4'd0);
        applyStimulus(4'd7, 16'hFFFF, 16'h0001, 4'd0);
        applyStimulus(4'd4, 16'hFFFF, 16'h8001, 4'd0);
        applyStimulus(4'd2, 16'h5555, 16'h5555, 4'd0);
        applyStimulus(4'd7, 16'h8000, 16'h8000, 4'd0);
        applyStimulus(4'd0, 16'h8000, 16'h0000, 4'd15);
        applyStimulus(4'd1, 16'h0001, 16'h0000, 4'd1);
        drain();

        // Stall: with out_ready low only two bundles fit, then streaming resumes gap-free
        readyForce = 1'b0;
        @(posedge clk);
        #2;
        deliverCycles.delete();
        applyStimulus(4'd4, 16'h0000, 16'h1111, 4'd0);
        applyStimulus(4'd4, 16'h0000, 16'h2222, 4'd0);
        driveInputs(4'd5, 16'h0F0F, 16'h00FF, 4'd0);
        repeat (4) begin
            @(negedge clk);
            checkOutput("stall_in_ready", 64'(in_ready), 64'd0);
        end
        checkOutput("stall_accepted", 64'(sb.size()), 64'd2);
        readyForce = 1'b1;
        applyStimulus(4'd5, 16'h0F0F, 16'h00FF, 4'd0);
        applyStimulus(4'd0, 16'h1234, 16'h0000, 4'd8);
        drain();
        checkOutput("stall_count", 64'(deliverCycles.size()), 64'd4);
        if (deliverCycles.size() >= 4)
            checkOutput("stall_stream", 64'(deliverCycles[3] - deliverCycles[0]), 64'd3);

        // Reset with two bundles in flight: both discarded, nothing stale afterwards
        readyForce = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #2;
        applyStimulus(4'd4, 16'h0000, 16'hAAAA, 4'd0);
        applyStimulus(4'd4, 16'h0000, 16'hBBBB, 4'd0);
        rst_n = 1'b0;
        driveInputs(4'd4, 16'h0000, 16'hCCCC, 4'd0);
        readyForce = 1'b1;
        repeat (2) @(posedge clk);
        #2;
        rst_n    = 1'b1;
        in_valid = 1'b0;
        @(negedge clk);
        checkOutput("mid_rst_out_valid", 64'(out_valid), 64'd0);
        checkOutput("mid_rst_result", 64'(result), 64'd0);
        checkOutput("mid_rst_flags", 64'({carryFlag, zeroFlag, signFlag}), 64'd0);
        checkOutput("mid_rst_in_ready", 64'(in_ready), 64'd1);
        repeat (5) begin
            @(negedge clk);
            checkOutput("no_stale", 64'(out_valid), 64'd0);
        end
        @(posedge clk);
        #2;

        // Random traffic with random backpressure
        randBp = 1'b1;
        for (int i = 0; i < 60; i++) begin
            applyStimulus(4'($urandom_range(0, 9)), 16'($urandom), 16'($urandom), 4'($urandom));
        end
        randBp = 1'b0;
        drain();

        // Illegal opcode yields zero; the status bit sticks until reset
        applyStimulus(4'hF, 16'h1234, 16'h5678, 4'd2);
        applyStimulus(4'd2, 16'h0010, 16'h0020, 4'd0);
        drain();
`ifdef ALU_ILLEGAL_OP_EN
        checkOutput("illegal_sticky", 64'(illegalOp), 64'd1);
        rst_n = 1'b0;
        @(posedge clk);
        #2;
        rst_n = 1'b1;
        @(negedge clk);
        checkOutput("illegal_cleared", 64'(illegalOp), 64'd0);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
        $finish;
    end

endmodule
